// File: rtl/vga_pkg.sv
// Shared raster types and the default 640x480@60 timing constants (50 MHz system clock).
package vga_pkg;

  typedef enum logic [1:0] {FP, SYNC, BP, ACT} vga_phase_t;

  localparam int CNT_W = 10;

  localparam int DEF_CLK_DIV = 2;
  localparam int DEF_H_FP    = 16;
  localparam int DEF_H_SYNC  = 96;
  localparam int DEF_H_BP    = 48;
  localparam int DEF_H_ACT   = 640;
  localparam int DEF_V_FP    = 10;
  localparam int DEF_V_SYNC  = 2;
  localparam int DEF_V_BP    = 33;
  localparam int DEF_V_ACT   = 480;

  localparam int H_BLANK = DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_BLANK = DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int H_TOTAL = H_BLANK + DEF_H_ACT;
  localparam int V_TOTAL = V_BLANK + DEF_V_ACT;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a position counter plus a FP/SYNC/BP/ACT phase FSM that advances on step.
module vga_axis_counter #(
  parameter int FP   = 16,
  parameter int SYNC = 96,
  parameter int BP   = 48,
  parameter int ACT  = 640
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       step,
  output logic [vga_pkg::CNT_W-1:0]  count,
  output vga_pkg::vga_phase_t        phase,
  output vga_pkg::vga_phase_t        phase_nxt,
  output logic                       wrap
);

  localparam int W     = vga_pkg::CNT_W;
  localparam int TOTAL = FP + SYNC + BP + ACT;

  localparam logic [W-1:0] LAST_FP   = W'(FP - 1);
  localparam logic [W-1:0] LAST_SYNC = W'(FP + SYNC - 1);
  localparam logic [W-1:0] LAST_BP   = W'(FP + SYNC + BP - 1);
  localparam logic [W-1:0] LAST      = W'(TOTAL - 1);

  logic [W-1:0]        count_q, count_d;
  vga_pkg::vga_phase_t phase_q, phase_d;

  assign wrap = (count_q == LAST);

  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    if (step) begin
      count_d = wrap ? '0 : count_q + 1'b1;
      case (phase_q)
        vga_pkg::FP:   if (count_q == LAST_FP)   phase_d = vga_pkg::SYNC;
        vga_pkg::SYNC: if (count_q == LAST_SYNC) phase_d = vga_pkg::BP;
        vga_pkg::BP:   if (count_q == LAST_BP)   phase_d = vga_pkg::ACT;
        vga_pkg::ACT:  if (wrap)                 phase_d = vga_pkg::FP;
        default:                                 phase_d = vga_pkg::FP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
      phase_q <= vga_pkg::FP;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
    end
  end

  assign count     = count_q;
  assign phase     = phase_q;
  // The next phase lets the parent register sync/active in step with the counter.
  assign phase_nxt = phase_d;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel divider, column/row axes, registered sync/active/frame strobes.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int H_FP    = DEF_H_FP,
  parameter int H_SYNC  = DEF_H_SYNC,
  parameter int H_BP    = DEF_H_BP,
  parameter int H_ACT   = DEF_H_ACT,
  parameter int V_FP    = DEF_V_FP,
  parameter int V_SYNC  = DEF_V_SYNC,
  parameter int V_BP    = DEF_V_BP,
  parameter int V_ACT   = DEF_V_ACT
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             enable,
  output logic             pixel_clk,
  output logic [CNT_W-1:0] colcnt,
  output logic [CNT_W-1:0] rowcnt,
  output logic             hsync,
  output logic             vsync,
  output logic             active,
  output logic             frame_start
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_ACT_START = CNT_W'(H_FP + H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] V_ACT_START = CNT_W'(V_FP + V_SYNC + V_BP);

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;
  logic             h_wrap, v_wrap;
  vga_phase_t       h_phase, h_phase_nxt, v_phase, v_phase_nxt;

  logic pixel_clk_q, frame_start_q, hsync_q, vsync_q, active_q;

  assign tick  = enable && (div_q == DIV_LAST);
  assign div_d = (enable && !tick) ? div_q + 1'b1 : '0;

  vga_axis_counter #(
    .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .ACT(H_ACT)
  ) u_h_axis (
    .clk(clk), .n_rst(n_rst), .step(tick),
    .count(colcnt), .phase(h_phase), .phase_nxt(h_phase_nxt), .wrap(h_wrap)
  );

  vga_axis_counter #(
    .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .ACT(V_ACT)
  ) u_v_axis (
    .clk(clk), .n_rst(n_rst), .step(tick && h_wrap),
    .count(rowcnt), .phase(v_phase), .phase_nxt(v_phase_nxt), .wrap(v_wrap)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      div_q         <= '0;
      pixel_clk_q   <= 1'b0;
      frame_start_q <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      active_q      <= 1'b0;
    end else begin
      div_q         <= div_d;
      pixel_clk_q   <= tick;
      frame_start_q <= tick && h_wrap && v_wrap;
      // Strobes follow the next phase so they always describe the counters beside them.
      if (tick) begin
        hsync_q  <= (h_phase_nxt != SYNC);
        vsync_q  <= (v_phase_nxt != SYNC);
        active_q <= (h_phase_nxt == ACT) && (v_phase_nxt == ACT);
      end
    end
  end

  assign pixel_clk   = pixel_clk_q;
  assign frame_start = frame_start_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign active      = active_q;

  h_phase_matches_col: assert property (@(posedge clk) disable iff (!n_rst)
    (h_phase == ACT) == (colcnt >= H_ACT_START));
  v_phase_matches_row: assert property (@(posedge clk) disable iff (!n_rst)
    (v_phase == ACT) == (rowcnt >= V_ACT_START));

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a small-raster instance and a default 640x480 instance, both checked
// every cycle against a linear pixel-index model, plus literal expectations on both.
module tb_vga_timing_gen;

  typedef struct {
    int cdiv; int hfp; int hsync; int hblank; int htot;
    int vfp;  int vsync; int vblank; int vtot;
  } tim_t;

  typedef struct {
    int div; int pos; bit pix; bit fs;
  } model_t;

  localparam tim_t T_S = '{cdiv:3, hfp:3,  hsync:4,  hblank:9,   htot:20,
                           vfp:2,  vsync:2, vblank:7, vtot:13};
  localparam tim_t T_D = '{cdiv:2, hfp:16, hsync:96, hblank:160, htot:800,
                           vfp:10, vsync:2, vblank:45, vtot:525};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic n_rst = 1'b1;
  logic enable = 1'b1;
  always #5 clk = ~clk;

  logic       s_pix, s_hs, s_vs, s_act, s_fs;
  logic [9:0] s_col, s_row;
  logic       d_pix, d_hs, d_vs, d_act, d_fs;
  logic [9:0] d_col, d_row;

  vga_timing_gen #(
    .CLK_DIV(3), .H_FP(3), .H_SYNC(4), .H_BP(2), .H_ACT(11),
    .V_FP(2), .V_SYNC(2), .V_BP(3), .V_ACT(6)
  ) dut_s (
    .clk(clk), .n_rst(n_rst), .enable(enable),
    .pixel_clk(s_pix), .colcnt(s_col), .rowcnt(s_row),
    .hsync(s_hs), .vsync(s_vs), .active(s_act), .frame_start(s_fs)
  );

  vga_timing_gen dut_d (
    .clk(clk), .n_rst(n_rst), .enable(enable),
    .pixel_clk(d_pix), .colcnt(d_col), .rowcnt(d_row),
    .hsync(d_hs), .vsync(d_vs), .active(d_act), .frame_start(d_fs)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Position is a single pixel index within the frame; col/row and strobes are derived from it.
  function automatic model_t model_next(input model_t m, input bit en, input tim_t t);
    model_t n = m;
    n.pix = 1'b0;
    n.fs  = 1'b0;
    if (!en) begin
      n.div = 0;
    end else if (m.div == t.cdiv - 1) begin
      n.div = 0;
      n.pix = 1'b1;
      n.pos = (m.pos + 1) % (t.htot * t.vtot);
      n.fs  = (n.pos == 0);
    end else begin
      n.div = m.div + 1;
    end
    return n;
  endfunction

  function automatic logic [24:0] exp_out(input model_t m, input tim_t t);
    int  col = m.pos % t.htot;
    int  row = m.pos / t.htot;
    bit  hs  = !(col >= t.hfp && col < t.hfp + t.hsync);
    bit  vs  = !(row >= t.vfp && row < t.vfp + t.vsync);
    bit  act = (col >= t.hblank) && (row >= t.vblank);
    return {m.pix, 10'(col), 10'(row), hs, vs, act, m.fs};
  endfunction

  model_t ms = '{div:0, pos:0, pix:1'b0, fs:1'b0};
  model_t md = '{div:0, pos:0, pix:1'b0, fs:1'b0};

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ms = '{div:0, pos:0, pix:1'b0, fs:1'b0};
      md = '{div:0, pos:0, pix:1'b0, fs:1'b0};
    end else begin
      ms = model_next(ms, enable, T_S);
      md = model_next(md, enable, T_D);
    end
  end

  // ---------------- scoreboard: every cycle ----------------
  always @(negedge clk) begin
    check("small outputs {pix,col,row,hs,vs,act,fs}",
          32'({s_pix, s_col, s_row, s_hs, s_vs, s_act, s_fs}), 32'(exp_out(ms, T_S)));
    check("default outputs {pix,col,row,hs,vs,act,fs}",
          32'({d_pix, d_col, d_row, d_hs, d_vs, d_act, d_fs}), 32'(exp_out(md, T_D)));
  end

  // ---------------- raster statistics ----------------
  bit stats_on = 1'b0;
  int fs_cnt = 0, ticks = 0, clks = 0, act_t = 0, vs_low = 0, hs_low = 0;
  int frame_ticks = -1, frame_clks = -1, frame_act = -1, frame_vs = -1, frame_hs = -1;
  int first_act_col = -1, first_act_row = -1, fs_nopix = 0;
  int d_hs_low = 0, d_hs_min = 9999, d_hs_max = -1, d_act_seen = 0;
  int d_prev_col = -1, d_prev_row = -1;
  bit d_wrap_ok = 1'b0;

  always @(negedge clk) begin
    if (s_fs && !s_pix) fs_nopix++;
    if (stats_on) begin
      if (s_pix) begin
        if (s_fs) begin
          if (fs_cnt == 1) begin
            frame_ticks = ticks; frame_clks = clks; frame_act = act_t;
            frame_vs = vs_low;   frame_hs = hs_low;
          end
          fs_cnt++;
          ticks = 0; clks = 0; act_t = 0; vs_low = 0; hs_low = 0;
        end
        ticks++;
        if (s_act) act_t++;
        if (!s_vs) vs_low++;
        if (!s_hs) hs_low++;
        if (s_act && first_act_col < 0) begin
          first_act_col = int'(s_col);
          first_act_row = int'(s_row);
        end
      end
      clks++;
      if (d_pix) begin
        if (d_row == 10'd0 && !d_hs) begin
          d_hs_low++;
          if (int'(d_col) < d_hs_min) d_hs_min = int'(d_col);
          if (int'(d_col) > d_hs_max) d_hs_max = int'(d_col);
        end
        if (d_act) d_act_seen++;
        if (d_prev_col == 799 && d_prev_row == 0 && d_col == 10'd0 && d_row == 10'd1)
          d_wrap_ok = 1'b1;
        d_prev_col = int'(d_col);
        d_prev_row = int'(d_row);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_small_tick_at(input int col, input int row, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(s_pix && s_col == 10'(col) && s_row == 10'(row)) && n < budget);
    check($sformatf("reached small (%0d,%0d) within budget", col, row),
          32'(s_pix && s_col == 10'(col) && s_row == 10'(row)), 32'd1);
  endtask

  task automatic check_reset_values();
    check("reset small pix/col/row",  32'({s_pix, s_col, s_row}), 32'd0);
    check("reset small hs/vs/act/fs", 32'({s_hs, s_vs, s_act, s_fs}), 32'b1100);
    check("reset default pix/col/row",  32'({d_pix, d_col, d_row}), 32'd0);
    check("reset default hs/vs/act/fs", 32'({d_hs, d_vs, d_act, d_fs}), 32'b1100);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    #1 n_rst = 1'b0;
    #20;
    check_reset_values();

    // release with enable high: default tick lands on the 2nd edge, then every 2nd edge
    @(negedge clk);
    n_rst = 1'b1;
    stats_on = 1'b1;
    @(posedge clk); #1;
    check("default edge1 pixel_clk", 32'(d_pix), 32'd0);
    @(posedge clk); #1;
    check("default edge2 {pix,col,row}", 32'({d_pix, d_col, d_row}), {11'd0, 1'b1, 10'd1, 10'd0});
    @(posedge clk); #1;
    check("default edge3 pixel_clk", 32'(d_pix), 32'd0);
    @(posedge clk); #1;
    check("default edge4 {pix,col}", 32'({d_pix, d_col}), {21'd0, 1'b1, 10'd2});

    repeat (1696) @(negedge clk);
    stats_on = 1'b0;
    check("default hsync-low ticks on row 0", 32'(d_hs_low), 32'd96);
    check("default first hsync-low col", 32'(d_hs_min), 32'd16);
    check("default last hsync-low col", 32'(d_hs_max), 32'd111);
    check("default 799->0 wrap bumps row", 32'(d_wrap_ok), 32'd1);
    check("default active on early rows", 32'(d_act_seen), 32'd0);
    check("small frame_start count", 32'(fs_cnt), 32'd2);
    check("small ticks per frame", 32'(frame_ticks), 32'd260);
    check("small clks between frame_start", 32'(frame_clks), 32'd780);
    check("small active ticks per frame", 32'(frame_act), 32'd66);
    check("small vsync-low ticks per frame", 32'(frame_vs), 32'd40);
    check("small hsync-low ticks per frame", 32'(frame_hs), 32'd52);
    check("small first active col", 32'(first_act_col), 32'd9);
    check("small first active row", 32'(first_act_row), 32'd7);

    // hold for 37 clocks mid-frame, then resume from the held position
    wait_small_tick_at(15, 9, 2000);
    enable = 1'b0;
    repeat (37) @(negedge clk);
    check("hold small {pix,col,row}", 32'({s_pix, s_col, s_row}), {11'd0, 1'b0, 10'd15, 10'd9});
    check("hold small active", 32'(s_act), 32'd1);
    enable = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_pix && n < 10);
    check("resume latency in clks", 32'(n), 32'd3);
    check("resume small {col,row}", 32'({s_col, s_row}), {12'd0, 10'd16, 10'd9});

    // randomized run/hold
    repeat (3000) begin
      @(negedge clk);
      enable = ($urandom_range(0, 7) != 0);
    end
    enable = 1'b1;

    // asynchronous reset mid-line
    wait_small_tick_at(12, 10, 2000);
    #2 n_rst = 1'b0;
    #1;
    check_reset_values();
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_fs && n < 1000);
    check("clks from restart to first small frame_start", 32'(n), 32'd780);
    check("frame_start without pixel_clk", 32'(fs_nopix), 32'd0);

    repeat (20) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
